mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-stage load/store unit of the 5-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs and issues word loads and stores to data memory over a valid/ready request channel with a separate response channel. While an access is outstanding it stalls the front of the pipeline. It resolves taken branches into a redirect, and registers the MEM/WB values for write-back.

## Interface
- TIMEOUT, 64: maximum cycles spent in REQ+RESP before an access is aborted; ≥1.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mem_alu_result  in  32  ALU result / effective address
- mem_rs2_val  in  32  store data
- mem_rd  in  5  destination register
- mem_RW  in  1  register write enable
- mem_MR  in  1  load
- mem_MW  in  1  store
- mem_branch  in  1  branch instruction
- mem_branch_target  in  32  branch target PC
- mem_branch_taken  in  1  branch outcome
- mem_stall  out  1  hold EX/MEM and upstream registers (drives their enable = ~mem_stall)
- redirect_valid  out  1  taken-branch redirect, combinational
- redirect_pc  out  32  = mem_branch_target
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_addr  out  32  = mem_alu_result
- dmem_req_we  out  1  1 = store
- dmem_req_wdata  out  32  = mem_rs2_val
- dmem_resp_valid  in  1  response / store ack
- dmem_resp_rdata  in  32  load data
- wb_RW  out  1  registered write enable to WB
- wb_rd  out  5  registered destination
- wb_data  out  32  registered load data or ALU result
- misalign_err  out  1  one-cycle registered pulse
- timeout_err  out  1  one-cycle registered pulse

## Operation
- The EX/MEM register has no valid bit. An all-zero entry is a bubble (MR=MW=RW=branch=0).
- access = (mem_MR | mem_MW) & (mem_alu_result[1:0]==0). misaligned = (mem_MR | mem_MW) & (mem_alu_result[1:0]!=0).
- FSM states: IDLE, REQ, RESP.
  - IDLE: if access, go to REQ and clear the timeout counter. Otherwise stay in IDLE.
  - REQ: dmem_req_valid=1. On dmem_req_ready, go to RESP.
  - RESP: on dmem_resp_valid, the access completes and the FSM returns to IDLE. Stores also wait for the ack.
- Counter: increments each cycle in REQ/RESP that does not complete the access. When it equals TIMEOUT and the cycle does not complete, the access aborts: go to IDLE and pulse timeout_err next cycle.
- mem_stall = (IDLE & access) | REQ | (RESP & ~dmem_resp_valid & ~abort). In REQ, abort also releases the stall.
- WB register update on each edge:
  - Completing load: wb_RW=mem_RW, wb_rd=mem_rd, wb_data=dmem_resp_rdata.
  - Non-memory entry in IDLE: wb_RW=mem_RW, wb_rd=mem_rd, wb_data=mem_alu_result.
  - Stall, abort, misaligned entry or completing store: wb_RW=0 (bubble). wb_rd and wb_data keep their previous values.
- misaligned entry: no bus request, no stall. It retires as a bubble and pulses misalign_err.
- redirect_valid = mem_branch & mem_branch_taken & ~mem_stall.
- dmem_resp_valid in IDLE or REQ is ignored. This includes late responses after a timeout.

## Timing
- Reset values: state IDLE, counter 0, wb_RW 0, wb_rd 0, wb_data 0, misalign_err 0, timeout_err 0. dmem_req_valid is 0 in the first cycle after reset.
- Reset mid-access: the FSM returns to IDLE and drops dmem_req_valid immediately. Any outstanding response is then ignored.
- Non-memory instruction latency: 1 cycle, no stall.
- Load/store minimum latency: 3 cycles (IDLE detect, REQ with ready, RESP with resp_valid). mem_stall is high for the first 2 of those cycles.
- Request signals hold stable while valid & ~ready, because the inputs are frozen by the stall.
- The earliest response is accepted in the cycle after the request handshake. A response in the same cycle as the handshake is ignored.
- Back-to-back memory ops: the following entry is evaluated in IDLE on the cycle after completion.

## Structure
- The shared package holds the FSM state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2) and the word-alignment mask constant.
- Natural sub-module: mem_stage_wb_reg, the MEM/WB output register with bubble insertion. The FSM and counter stay in the top module.

## Test plan
- ALU op: RW=1, rd=5, alu_result=0x1234 -> no stall; next cycle wb_RW=1, wb_rd=5, wb_data=0x1234.
- Load addr 0x100, ready immediate, resp one cycle later with rdata 0xDEADBEEF -> stall for 2 cycles, dmem_req_we=0; wb_data=0xDEADBEEF with wb_RW=1 after completion.
- Store addr 0x200, rs2=0xCAFE, ready low for 3 cycles, then high, then ack -> addr/wdata held stable throughout; wb_RW stays 0; stall released on the ack cycle.
- Load addr 0x102 -> no dmem_req_valid; misalign_err pulses once; wb_RW=0.
- TIMEOUT=4, ready high, resp never arrives -> abort; timeout_err pulses; stall released. A late resp_valid later is ignored and wb is unchanged.
- Taken branch to 0x80 with no memory op -> redirect_valid=1, redirect_pc=0x80 in the same cycle. Reset asserted in RESP -> next cycle state IDLE, all outputs at their reset values.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_pkg
// Shared definitions for the memory-stage load/store unit:
//   - lsu_state_e      : access FSM state encoding (IDLE, REQ, RESP)
//   - WORD_ALIGN_MASK  : address bits that must be zero for a word access
//   - is_word_aligned(): helper applying the mask to an effective address
// -----------------------------------------------------------------------------
package mem_stage_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } lsu_state_e;

   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_stage_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_stage_wb_reg
// MEM/WB output register with bubble insertion.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en             : an instruction retires this cycle; capture its fields
//   wr_rw/wr_rd/wr_data : fields of the retiring instruction
//   wb_RW/wb_rd/wb_data : registered values presented to write-back
// When wr_en is low a bubble is inserted: wb_RW clears while wb_rd and wb_data
// keep their last values.
// -----------------------------------------------------------------------------
module mem_stage_wb_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        wr_rw,
   input  logic [4:0]  wr_rd,
   input  logic [31:0] wr_data,
   output logic        wb_RW,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_RW   <= 1'b0;
         wb_rd   <= 5'd0;
         wb_data <= 32'd0;
      end else if (wr_en) begin
         wb_RW   <= wr_rw;
         wb_rd   <= wr_rd;
         wb_data <= wr_data;
      end else begin
         wb_RW   <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// Memory-stage load/store unit of the 5-stage pipeline. Takes the EX/MEM
// register outputs, issues word loads/stores over a request/response bus,
// stalls the front of the pipeline while an access is outstanding, resolves
// taken branches into a redirect and registers the MEM/WB values.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   mem_*                   : EX/MEM register outputs (all-zero entry = bubble)
//   mem_stall               : hold EX/MEM and upstream registers
//   redirect_valid/_pc      : taken-branch redirect (combinational)
//   dmem_req_*              : data memory request channel
//   dmem_resp_*             : data memory response channel (load data / store ack)
//   wb_RW, wb_rd, wb_data   : registered MEM/WB values
//   misalign_err            : one-cycle pulse for a misaligned load/store
//   timeout_err             : one-cycle pulse for an aborted access
//   dbg_state               : current FSM state (lsu_state_e encoding)
//
// Handshake: a request transfers on a cycle where dmem_req_valid and
// dmem_req_ready are both high; once valid is raised, the request fields stay
// stable until that transfer because the stall freezes the EX/MEM inputs. A
// response is taken on any cycle in RESP where dmem_resp_valid is high; it has
// no ready, and responses seen in IDLE or REQ are dropped.
// -----------------------------------------------------------------------------
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_rs2_val,
   input  logic [4:0]  mem_rd,
   input  logic        mem_RW,
   input  logic        mem_MR,
   input  logic        mem_MW,
   input  logic        mem_branch,
   input  logic [31:0] mem_branch_target,
   input  logic        mem_branch_taken,
   output logic        mem_stall,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic [31:0] dmem_req_addr,
   output logic        dmem_req_we,
   output logic [31:0] dmem_req_wdata,
   input  logic        dmem_resp_valid,
   input  logic [31:0] dmem_resp_rdata,
   output logic        wb_RW,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign_err,
   output logic        timeout_err,
   output logic [1:0]  dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

   lsu_state_e    state;
   logic [CW-1:0] cnt;

   logic mem_op, aligned, access, misaligned;
   logic in_idle, in_req, in_resp;
   logic complete, abort;
   logic wb_wr_en;
   logic [31:0] wb_wr_data;

   assign mem_op     = mem_MR | mem_MW;
   assign aligned    = is_word_aligned(mem_alu_result);
   assign access     = mem_op & aligned;
   assign misaligned = mem_op & ~aligned;

   assign in_idle = (state == IDLE);
   assign in_req  = (state == REQ);
   assign in_resp = (state == RESP);

   // A response can only finish the access in RESP; completion wins over
   // the timeout on the cycle the counter reaches its limit.
   assign complete = in_resp & dmem_resp_valid;
   assign abort    = (in_req | in_resp) & (cnt == CNT_LIMIT) & ~complete;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         misalign_err <= in_idle & misaligned;
         timeout_err  <= abort;
         case (state)
            IDLE: begin
               if (access) begin
                  state <= REQ;
                  cnt   <= '0;
               end
            end
            REQ: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (dmem_req_ready) state <= RESP;
               end
            end
            RESP: begin
               if (complete || abort) state <= IDLE;
               else                   cnt   <= cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state = state;

   assign mem_stall = (in_idle & access)
                    | (in_req & ~abort)
                    | (in_resp & ~dmem_resp_valid & ~abort);

   assign redirect_valid = mem_branch & mem_branch_taken & ~mem_stall;
   assign redirect_pc    = mem_branch_target;

   assign dmem_req_valid = in_req;
   assign dmem_req_addr  = mem_alu_result;
   assign dmem_req_we    = mem_MW;
   assign dmem_req_wdata = mem_rs2_val;

   // Retire into WB: completing loads carry the bus data, non-memory entries
   // seen in IDLE carry the ALU result. Everything else becomes a bubble.
   assign wb_wr_en   = (in_idle & ~mem_op) | (complete & ~mem_MW);
   assign wb_wr_data = in_idle ? mem_alu_result : dmem_resp_rdata;

   mem_stage_wb_reg u_wb_reg (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wb_wr_en),
      .wr_rw   (mem_RW),
      .wr_rd   (mem_rd),
      .wr_data (wb_wr_data),
      .wb_RW   (wb_RW),
      .wb_rd   (wb_rd),
      .wb_data (wb_data)
   );

endmodule
